// File: rtl/wb_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter: round-robin grant held for the whole
// cycle, outstanding-strobe cap and a no-ack watchdog that aborts with err.
module wb_arbiter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_stall_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_stall_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_stall_i
);

    localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLIM  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0]    CAP   = 4'(MAX_OUTSTANDING);
    localparam bit            WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last_grant, w_last_nxt;
    logic [3:0]    r_outstanding, w_out_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;

    logic          w_gnt0, w_gnt1, w_gnt;
    logic          w_cyc, w_stb, w_we;
    logic [3:0]    w_sel;
    logic [31:0]   w_adr, w_dat;
    logic          w_cap, w_release, w_timeout, w_scyc, w_sstb, w_accept;

    // Holding rst_n in the grant terms forces every slave output, ack and err low during reset.
    assign w_gnt0 = rst_n && (r_state == GNT0);
    assign w_gnt1 = rst_n && (r_state == GNT1);
    assign w_gnt  = w_gnt0 | w_gnt1;

    assign w_cyc = w_gnt1 ? m1_cyc_i : m0_cyc_i;
    assign w_stb = w_gnt1 ? m1_stb_i : m0_stb_i;
    assign w_we  = w_gnt1 ? m1_we_i  : m0_we_i;
    assign w_sel = w_gnt1 ? m1_sel_i : m0_sel_i;
    assign w_adr = w_gnt1 ? m1_adr_i : m0_adr_i;
    assign w_dat = w_gnt1 ? m1_dat_i : m0_dat_i;

    assign w_cap     = (r_outstanding == CAP);
    assign w_release = w_gnt & ~w_cyc;
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle with work pending and no ack.
    assign w_timeout = WD_EN && w_gnt && w_cyc && (r_outstanding != 4'd0) && !s_ack_i
                       && (r_timer == TLIM);
    assign w_scyc    = w_gnt & w_cyc & ~w_timeout;
    assign w_sstb    = w_scyc & w_stb & ~w_cap;
    assign w_accept  = w_sstb & ~s_stall_i;

    assign s_cyc_o = w_scyc;
    assign s_stb_o = w_sstb;
    assign s_we_o  = w_gnt & w_we;
    assign s_sel_o = w_gnt ? w_sel : 4'd0;
    assign s_adr_o = w_gnt ? w_adr : 32'd0;
    assign s_dat_o = w_gnt ? w_dat : 32'd0;

    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;
    assign m0_ack_o   = w_gnt0 & s_ack_i;
    assign m1_ack_o   = w_gnt1 & s_ack_i;
    assign m0_err_o   = w_gnt0 & w_timeout;
    assign m1_err_o   = w_gnt1 & w_timeout;
    assign m0_stall_o = w_gnt0 ? (s_stall_i | w_cap) : m0_cyc_i;
    assign m1_stall_o = w_gnt1 ? (s_stall_i | w_cap) : m1_cyc_i;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_grant ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end else if (w_timeout) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end else if (w_timeout) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_out_nxt   = r_outstanding;
        w_timer_nxt = r_timer;
        if (!w_gnt || w_release || w_timeout) begin
            w_out_nxt   = 4'd0;
            w_timer_nxt = '0;
        end else begin
            if (w_accept && !s_ack_i) begin
                w_out_nxt = r_outstanding + 4'd1;
            end else if (!w_accept && s_ack_i && (r_outstanding != 4'd0)) begin
                w_out_nxt = r_outstanding - 4'd1;
            end
            if (s_ack_i || (r_outstanding == 4'd0)) begin
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_outstanding <= 4'd0;
            r_timer       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_nxt;
            r_outstanding <= w_out_nxt;
            r_timer       <= w_timer_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: arbitration, hand-over, outstanding cap,
// simultaneous accept/ack, watchdog abort and mid-cycle reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_stall_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_stall_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_stall_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_stall_o(m0_stall_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_stall_o(m1_stall_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_stall_i(s_stall_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hF;
        m0_adr_i = 32'h1000_0000; m0_dat_i = 32'hAAAA_0000;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hF;
        m1_adr_i = 32'h2000_0000; m1_dat_i = 32'hBBBB_0000;
        s_ack_i = 0; s_stall_i = 0; s_dat_i = 32'h5555_AAAA;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        nxt();
        nxt();
        rst_n = 1;
    endtask

    int acks;
    int errs;

    initial begin
        // Reset with active-looking inputs: everything slave-side and ack must stay low.
        idle_in();
        rst_n = 0;
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        nxt(); settle();
        check("rst s_cyc", s_cyc_o, 0);
        check("rst s_stb", s_stb_o, 0);
        check("rst s_adr", s_adr_o, 0);
        check("rst m0_ack", m0_ack_o, 0);
        check("rst m0_err", m0_err_o, 0);

        // Test 1: only m0, single write, 1-cycle ack.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'h3;
        m0_adr_i = 32'h8000_0010; m0_dat_i = 32'h1234_5678;
        settle();
        check("t1 c0 m0_stall", m0_stall_o, 1);
        check("t1 c0 s_cyc", s_cyc_o, 0);
        nxt(); settle();
        check("t1 c1 s_cyc", s_cyc_o, 1);
        check("t1 c1 s_stb", s_stb_o, 1);
        check("t1 c1 s_adr", s_adr_o, 32'h8000_0010);
        check("t1 c1 s_we", s_we_o, 1);
        check("t1 c1 s_sel", s_sel_o, 4'h3);
        check("t1 c1 s_dat", s_dat_o, 32'h1234_5678);
        check("t1 c1 m0_stall", m0_stall_o, 0);
        nxt();
        m0_stb_i = 0; s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
        settle();
        check("t1 c2 m0_ack", m0_ack_o, 1);
        check("t1 c2 m1_ack", m1_ack_o, 0);
        check("t1 c2 m0_dat", m0_dat_o, 32'hCAFE_F00D);
        check("t1 c2 m1_dat", m1_dat_o, 32'hCAFE_F00D);
        nxt();
        s_ack_i = 0; m0_cyc_i = 0;
        settle();
        check("t1 c3 s_cyc", s_cyc_o, 0);
        check("t1 c3 m0_ack", m0_ack_o, 0);

        // Test 2: tie to m0, hand-over to m1 without bubble, then alternation back to m0.
        do_reset();
        m0_cyc_i = 1; m1_cyc_i = 1;
        settle();
        check("t2 c0 m0_stall", m0_stall_o, 1);
        check("t2 c0 m1_stall", m1_stall_o, 1);
        nxt();
        m0_stb_i = 1;
        settle();
        check("t2 c1 s_adr", s_adr_o, 32'h1000_0000);
        check("t2 c1 s_stb", s_stb_o, 1);
        check("t2 c1 m0_stall", m0_stall_o, 0);
        check("t2 c1 m1_stall", m1_stall_o, 1);
        nxt();
        m0_stb_i = 0; s_ack_i = 1;
        settle();
        check("t2 c2 m0_ack", m0_ack_o, 1);
        check("t2 c2 m1_ack", m1_ack_o, 0);
        nxt(); s_ack_i = 0;
        nxt();
        nxt();
        m0_cyc_i = 0; m1_stb_i = 1;
        settle();
        check("t2 c5 s_cyc", s_cyc_o, 0);
        check("t2 c5 m1_stall", m1_stall_o, 1);
        nxt();
        m0_cyc_i = 1;
        settle();
        check("t2 c6 s_cyc", s_cyc_o, 1);
        check("t2 c6 s_adr", s_adr_o, 32'h2000_0000);
        check("t2 c6 s_stb", s_stb_o, 1);
        check("t2 c6 m1_stall", m1_stall_o, 0);
        check("t2 c6 m0_stall", m0_stall_o, 1);
        nxt();
        m1_stb_i = 0; s_ack_i = 1;
        settle();
        check("t2 c7 m1_ack", m1_ack_o, 1);
        check("t2 c7 m0_ack", m0_ack_o, 0);
        nxt();
        s_ack_i = 0; m0_cyc_i = 0; m1_cyc_i = 0;
        nxt();
        m0_cyc_i = 1; m1_cyc_i = 1;
        settle();
        check("t2 c9 s_cyc", s_cyc_o, 0);
        nxt();
        m0_stb_i = 1;
        settle();
        check("t2 c10 s_adr", s_adr_o, 32'h1000_0000);
        check("t2 c10 m1_stall", m1_stall_o, 1);
        nxt();
        m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        check("t2 c11 s_cyc", s_cyc_o, 0);
        nxt(); settle();
        check("t2 c12 s_cyc", s_cyc_o, 1);
        check("t2 c12 s_adr", s_adr_o, 32'h2000_0000);
        check("t2 c12 m1_stall", m1_stall_o, 0);
        nxt();
        m1_cyc_i = 0;

        // Test 3: 10 back-to-back strobes, acks held off until cycle 10.
        do_reset();
        acks = 0;
        for (int c = 0; c <= 21; c++) begin
            if (c > 0) nxt();
            m0_cyc_i = (c < 20);
            m0_stb_i = (c <= 12);
            s_ack_i  = (c >= 10 && c <= 19);
            settle();
            if (m0_ack_o) acks++;
            if (c <= 12)
                check($sformatf("t3 c%0d m0_stall", c), m0_stall_o,
                      32'((c == 0) || (c == 9) || (c == 10)));
        end
        check("t3 ack count", acks, 10);

        // Test 4: accept and ack together for 20 cycles, outstanding stays at 1.
        do_reset();
        for (int c = 0; c <= 23; c++) begin
            if (c > 0) nxt();
            m0_cyc_i = (c < 23);
            m0_stb_i = (c <= 21);
            s_ack_i  = (c >= 2 && c <= 22);
            settle();
            if (c >= 2 && c <= 21) begin
                check($sformatf("t4 c%0d m0_stall", c), m0_stall_o, 0);
                check($sformatf("t4 c%0d m0_ack", c), m0_ack_o, 1);
            end
        end

        // Test 5: unanswered read, watchdog of 16, m1 waiting throughout.
        do_reset();
        errs = 0;
        for (int c = 0; c <= 19; c++) begin
            if (c > 0) nxt();
            m0_cyc_i = (c <= 17);
            m0_stb_i = (c <= 1);
            m1_cyc_i = 1;
            settle();
            if (m0_err_o) errs++;
            check($sformatf("t5 c%0d m0_err", c), m0_err_o, 32'(c == 17));
            check($sformatf("t5 c%0d s_cyc", c), s_cyc_o, 32'((c >= 1 && c <= 16) || c == 19));
            if (c == 17) check("t5 c17 m1_err", m1_err_o, 0);
            if (c == 18) check("t5 c18 m1_stall", m1_stall_o, 1);
            if (c == 19) check("t5 c19 m1_stall", m1_stall_o, 0);
        end
        check("t5 err count", errs, 1);
        nxt();
        m1_cyc_i = 0;

        // Test 6: reset while m1 holds 3 outstanding after m0 had the previous grant.
        do_reset();
        m0_cyc_i = 1;
        nxt();
        nxt();
        m0_cyc_i = 0; m1_cyc_i = 1; m1_adr_i = 32'h3000_0000;
        settle();
        check("t6 c2 s_cyc", s_cyc_o, 0);
        nxt();
        m1_stb_i = 1;
        settle();
        check("t6 c3 s_cyc", s_cyc_o, 1);
        check("t6 c3 s_adr", s_adr_o, 32'h3000_0000);
        nxt();
        nxt();
        nxt();
        m1_stb_i = 0; rst_n = 0; s_ack_i = 1;
        settle();
        check("t6 c6 s_cyc", s_cyc_o, 0);
        check("t6 c6 m1_ack", m1_ack_o, 0);
        check("t6 c6 m1_err", m1_err_o, 0);
        nxt();
        rst_n = 1; m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h4000_0000;
        settle();
        check("t6 c7 s_cyc", s_cyc_o, 0);
        check("t6 c7 m0_ack", m0_ack_o, 0);
        check("t6 c7 m1_ack", m1_ack_o, 0);
        check("t6 c7 m0_stall", m0_stall_o, 1);
        nxt();
        s_ack_i = 0;
        settle();
        check("t6 c8 s_cyc", s_cyc_o, 1);
        check("t6 c8 s_adr", s_adr_o, 32'h4000_0000);
        check("t6 c8 m0_stall", m0_stall_o, 0);
        check("t6 c8 m1_stall", m1_stall_o, 1);
        nxt();
        idle_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
